// File: rtl/rdi_pkg.sv
// rtl/rdi_pkg.sv - RDI state codes and adapter TX FSM encodings
package rdi_pkg;

    typedef enum logic [3:0] {
        RDI_NOP       = 4'h0,
        RDI_ACTIVE    = 4'h1,
        RDI_L1        = 4'h4,
        RDI_LINKERROR = 4'hA
    } rdi_state_e;

    typedef enum logic [2:0] {
        FSM_RESET   = 3'd0,
        FSM_ACT_REQ = 3'd1,
        FSM_ACTIVE  = 3'd2,
        FSM_L1_REQ  = 3'd3,
        FSM_L1      = 3'd4,
        FSM_WAKE    = 3'd5,
        FSM_ERROR   = 3'd6
    } tx_fsm_e;

    // States in which the adapter waits on a PHY response and the timeout runs
    function automatic logic is_wait_state(input tx_fsm_e s);
        return (s == FSM_ACT_REQ) || (s == FSM_L1_REQ) || (s == FSM_WAKE);
    endfunction

endpackage

// File: rtl/rdi_tx_fifo.sv
// rtl/rdi_tx_fifo.sv - zero-latency TX buffer with flush and occupancy
module rdi_tx_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty; pointers wrap naturally
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; flush empties the buffer and overrides push/pop
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + LW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + LW'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rdi_tx_adapter.sv
// rtl/rdi_tx_adapter.sv - adapter-side RDI transmit controller
module rdi_tx_adapter
    import rdi_pkg::*;
#(
    parameter int NBYTES     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_CYCLES = 1024,
    parameter int CNT_W      = $clog2(TMO_CYCLES + 1)
) (
    input  logic                          lclk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NBYTES*8-1:0]           in_data,
    input  logic                          link_up_req,
    input  logic                          pm_req,
    input  logic                          link_err,
    output logic                          lp_irdy,
    output logic                          lp_valid,
    output logic [NBYTES*8-1:0]           lp_data,
    input  logic                          pl_trdy,
    output logic [3:0]                    lp_state_req,
    output logic                          lp_linkerror,
    input  logic [3:0]                    pl_state_sts,
    input  logic                          pl_stallreq,
    output logic                          lp_stallack,
    input  logic                          pl_clk_req,
    output logic                          lp_clk_ack,
    output logic                          lp_wake_req,
    input  logic                          pl_wake_ack,
    output logic [2:0]                    fsm_state,
    output logic                          tmo_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    tx_fsm_e              fsm_q;
    tx_fsm_e              fsm_d;
    rdi_state_e           req_e;
    logic [CNT_W-1:0]     tmo_cnt_q;
    logic                 tmo_hit;
    logic                 tmo_fire;
    logic                 err_entry;
    logic                 stallack_q;
    logic                 clk_ack_q;
    logic                 tmo_err_q;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 flush;
    logic [NBYTES*8-1:0]  fifo_head;

    assign err_entry = link_err || (pl_state_sts == RDI_LINKERROR);
    assign tmo_hit   = is_wait_state(fsm_q) && (tmo_cnt_q == CNT_W'(TMO_CYCLES - 1));

    // Next-state logic; error entry overrides every other transition
    always_comb begin
        fsm_d    = fsm_q;
        tmo_fire = 1'b0;
        if (err_entry) begin
            fsm_d = FSM_ERROR;
        end else begin
            case (fsm_q)
                FSM_RESET:   if (link_up_req) fsm_d = FSM_ACT_REQ;
                FSM_ACT_REQ: begin
                    if (pl_state_sts == RDI_ACTIVE) fsm_d = FSM_ACTIVE;
                    else if (tmo_hit) begin
                        fsm_d    = FSM_ERROR;
                        tmo_fire = 1'b1;
                    end
                end
                FSM_ACTIVE:  if (pm_req && fifo_empty && !stallack_q) fsm_d = FSM_L1_REQ;
                FSM_L1_REQ: begin
                    if (pl_state_sts == RDI_L1) fsm_d = FSM_L1;
                    else if (tmo_hit) begin
                        fsm_d    = FSM_ERROR;
                        tmo_fire = 1'b1;
                    end
                end
                FSM_L1:      if (link_up_req) fsm_d = FSM_WAKE;
                FSM_WAKE: begin
                    if (pl_wake_ack) fsm_d = FSM_ACT_REQ;
                    else if (tmo_hit) begin
                        fsm_d    = FSM_ERROR;
                        tmo_fire = 1'b1;
                    end
                end
                FSM_ERROR:   if (pl_state_sts == RDI_NOP) fsm_d = FSM_RESET;
                default:     fsm_d = FSM_RESET;
            endcase
        end
    end

    // State request decoded from the current registered state
    always_comb begin
        req_e = RDI_NOP;
        case (fsm_q)
            FSM_ACT_REQ, FSM_ACTIVE: req_e = RDI_ACTIVE;
            FSM_L1_REQ:              req_e = RDI_L1;
            FSM_ERROR:               req_e = RDI_LINKERROR;
            default:                 req_e = RDI_NOP;
        endcase
    end

    // State, timeout counter, sticky timeout flag and one-cycle handshake follows
    always_ff @(posedge lclk) begin
        if (!rst_n) begin
            fsm_q      <= FSM_RESET;
            tmo_cnt_q  <= '0;
            tmo_err_q  <= 1'b0;
            stallack_q <= 1'b0;
            clk_ack_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            stallack_q <= pl_stallreq;
            clk_ack_q  <= pl_clk_req;
            if (tmo_fire) tmo_err_q <= 1'b1;
            if ((fsm_d != fsm_q) || !is_wait_state(fsm_q)) tmo_cnt_q <= '0;
            else                                            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    assign lp_valid     = !fifo_empty && (fsm_q == FSM_ACTIVE) && !stallack_q &&
                          (pl_state_sts == RDI_ACTIVE);
    assign lp_irdy      = lp_valid;
    assign lp_data      = lp_valid ? fifo_head : '0;
    assign in_ready     = !fifo_full && (fsm_q == FSM_ACTIVE) && !pl_stallreq && !stallack_q;
    assign push         = in_valid && in_ready;
    assign pop          = lp_valid && pl_trdy;
    assign flush        = (fsm_d == FSM_ERROR);
    assign lp_state_req = req_e;
    assign lp_linkerror = (fsm_q == FSM_ERROR);
    assign lp_wake_req  = (fsm_q == FSM_WAKE);
    assign lp_stallack  = stallack_q;
    assign lp_clk_ack   = clk_ack_q;
    assign tmo_err      = tmo_err_q;
    assign fsm_state    = fsm_q;

    rdi_tx_fifo #(
        .WIDTH (NBYTES * 8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (lclk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_rdi_tx_adapter.sv
// tb/tb_rdi_tx_adapter.sv - randomized and directed bench for rdi_tx_adapter
module tb_rdi_tx_adapter;

    localparam int NB    = 4;
    localparam int W     = NB * 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          lclk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          link_up_req;
    logic          pm_req;
    logic          link_err;
    logic          lp_irdy;
    logic          lp_valid;
    logic [W-1:0]  lp_data;
    logic          pl_trdy;
    logic [3:0]    lp_state_req;
    logic          lp_linkerror;
    logic [3:0]    pl_state_sts;
    logic          pl_stallreq;
    logic          lp_stallack;
    logic          pl_clk_req;
    logic          lp_clk_ack;
    logic          lp_wake_req;
    logic          pl_wake_ack;
    logic [2:0]    fsm_state;
    logic          tmo_err;
    logic [2:0]    fifo_level;

    always #5 lclk = ~lclk;

    rdi_tx_adapter #(
        .NBYTES     (NB),
        .FIFO_DEPTH (DEPTH),
        .TMO_CYCLES (TMO)
    ) dut (
        .lclk         (lclk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .link_up_req  (link_up_req),
        .pm_req       (pm_req),
        .link_err     (link_err),
        .lp_irdy      (lp_irdy),
        .lp_valid     (lp_valid),
        .lp_data      (lp_data),
        .pl_trdy      (pl_trdy),
        .lp_state_req (lp_state_req),
        .lp_linkerror (lp_linkerror),
        .pl_state_sts (pl_state_sts),
        .pl_stallreq  (pl_stallreq),
        .lp_stallack  (lp_stallack),
        .pl_clk_req   (pl_clk_req),
        .lp_clk_ack   (lp_clk_ack),
        .lp_wake_req  (lp_wake_req),
        .pl_wake_ack  (pl_wake_ack),
        .fsm_state    (fsm_state),
        .tmo_err      (tmo_err),
        .fifo_level   (fifo_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: state number as listed in the state table, data as a queue
    int            m_st;
    logic [W-1:0]  m_q[$];
    int            m_wait;
    bit            m_tmo;
    bit            m_stall;
    bit            m_clk;
    logic [W-1:0]  got_q[$];
    bit            last_push;

    function automatic bit exp_valid();
        return (m_q.size() > 0) && (m_st == 2) && !m_stall && (pl_state_sts == 4'h1);
    endfunction

    function automatic bit exp_ready();
        return (m_q.size() < DEPTH) && (m_st == 2) && !pl_stallreq && !m_stall;
    endfunction

    function automatic logic [3:0] exp_req();
        case (m_st)
            1, 2:    return 4'h1;
            3:       return 4'h4;
            6:       return 4'hA;
            default: return 4'h0;
        endcase
    endfunction

    task automatic model_step();
        bit v, r, waiting, expired;
        int nx;
        v = exp_valid();
        r = exp_ready();
        if (!rst_n) begin
            m_st = 0; m_q.delete(); m_wait = 0; m_tmo = 0; m_stall = 0; m_clk = 0;
            return;
        end
        waiting = (m_st == 1) || (m_st == 3) || (m_st == 5);
        expired = waiting && (m_wait == TMO - 1);
        nx = m_st;
        if (link_err || pl_state_sts == 4'hA) nx = 6;
        else begin
            case (m_st)
                0: if (link_up_req) nx = 1;
                1: if (pl_state_sts == 4'h1) nx = 2; else if (expired) begin nx = 6; m_tmo = 1; end
                2: if (pm_req && m_q.size() == 0 && !m_stall) nx = 3;
                3: if (pl_state_sts == 4'h4) nx = 4; else if (expired) begin nx = 6; m_tmo = 1; end
                4: if (link_up_req) nx = 5;
                5: if (pl_wake_ack) nx = 1; else if (expired) begin nx = 6; m_tmo = 1; end
                6: if (pl_state_sts == 4'h0) nx = 0;
                default: nx = 0;
            endcase
        end
        if (nx == 6) m_q.delete();
        else begin
            if (v && pl_trdy) void'(m_q.pop_front());
            if (r && in_valid) m_q.push_back(in_data);
        end
        m_wait  = (nx == m_st && waiting) ? m_wait + 1 : 0;
        m_stall = pl_stallreq;
        m_clk   = pl_clk_req;
        m_st    = nx;
    endtask

    task automatic check_outputs();
        bit v;
        v = exp_valid();
        check("lp_valid",     lp_valid,     v);
        check("lp_irdy",      lp_irdy,      v);
        check("lp_data",      lp_data,      v ? m_q[0] : '0);
        check("in_ready",     in_ready,     exp_ready());
        check("lp_state_req", lp_state_req, exp_req());
        check("lp_linkerror", lp_linkerror, m_st == 6);
        check("lp_wake_req",  lp_wake_req,  m_st == 5);
        check("lp_stallack",  lp_stallack,  m_stall);
        check("lp_clk_ack",   lp_clk_ack,   m_clk);
        check("fsm_state",    fsm_state,    m_st);
        check("tmo_err",      tmo_err,      m_tmo);
        check("fifo_level",   fifo_level,   m_q.size());
    endtask

    // One clock: inputs already driven after the falling edge
    task automatic step();
        pl_clk_req = 1'($urandom_range(0, 1));
        #1;
        check_outputs();
        last_push = in_valid && in_ready;
        if (lp_valid && pl_trdy) got_q.push_back(lp_data);
        model_step();
        @(posedge lclk);
        @(negedge lclk);
    endtask

    task automatic push_words(input int n, input logic [W-1:0] base);
        int k = 0;
        for (int c = 0; c < 20 && k < n; c++) begin
            in_valid = 1'b1;
            in_data  = base + W'(k);
            step();
            if (last_push) k++;
        end
        in_valid = 1'b0;
        check("push_count", k, n);
    endtask

    task automatic drain();
        pl_trdy = 1'b1;
        for (int c = 0; c < 30 && fifo_level != 0; c++) step();
        check("drain_done", fifo_level, 0);
    endtask

    task automatic bring_up();
        link_up_req = 1'b1;
        step();
        link_up_req = 1'b0;
        pl_state_sts = 4'h1;
        step();
        check("bring_up_active", fsm_state, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, max_lvl, r;
        rst_n = 0; in_valid = 0; in_data = '0; link_up_req = 0; pm_req = 0; link_err = 0;
        pl_trdy = 0; pl_state_sts = 4'h0; pl_stallreq = 0; pl_clk_req = 0; pl_wake_ack = 0;
        m_st = 0; m_wait = 0; m_tmo = 0; m_stall = 0; m_clk = 0; last_push = 0;
        @(negedge lclk);
        step();
        step();
        rst_n = 1'b1;

        // Bring-up: PHY answers Active three cycles after the request
        link_up_req = 1'b1;
        step();
        link_up_req = 1'b0;
        check("bu_req_active", lp_state_req, 4'h1);
        step();
        step();
        pl_state_sts = 4'h1;
        step();
        check("bu_fsm_active", fsm_state, 2);
        check("bu_in_ready", in_ready, 1);

        // Streaming six words with the PHY stalled for five cycles
        got_q.delete();
        w = 1;
        max_lvl = 0;
        for (int c = 0; c < 60; c++) begin
            pl_trdy  = (c >= 5);
            in_valid = (w <= 6);
            in_data  = W'(w);
            step();
            if (last_push) w++;
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            if (w > 6 && fifo_level == 0) break;
        end
        in_valid = 1'b0;
        check("stream_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) check("stream_order", got_q[i], i + 1);
        check("stream_max_level", max_lvl, DEPTH);

        // Stall while a word is offered but not accepted
        got_q.delete();
        pl_trdy = 1'b0;
        push_words(2, 32'h11);
        check("stall_pre_valid", lp_valid, 1);
        pl_stallreq = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("stall_ack", lp_stallack, 1);
        check("stall_valid_low", lp_valid, 0);
        pl_stallreq = 1'b0;
        step();
        drain();
        check("stall_count", got_q.size(), 2);
        for (int i = 0; i < 2 && i < got_q.size(); i++) check("stall_order", got_q[i], 32'h11 + i);

        // L1 round trip: pending data holds off L1 entry
        pl_trdy = 1'b0;
        push_words(1, 32'h21);
        pm_req = 1'b1;
        step(); step(); step();
        check("l1_held_active", fsm_state, 2);
        pl_trdy = 1'b1;
        for (int c = 0; c < 10 && fsm_state != 3; c++) step();
        check("l1_req_state", fsm_state, 3);
        check("l1_req_code", lp_state_req, 4'h4);
        pm_req = 1'b0;
        pl_trdy = 1'b0;
        pl_state_sts = 4'h4;
        step();
        check("l1_state", fsm_state, 4);
        link_up_req = 1'b1;
        step();
        link_up_req = 1'b0;
        check("wake_req", lp_wake_req, 1);
        step(); step();
        pl_wake_ack = 1'b1;
        step();
        pl_wake_ack = 1'b0;
        check("wake_to_act_req", fsm_state, 1);
        check("wake_req_drop", lp_wake_req, 0);
        pl_state_sts = 4'h1;
        step();
        check("wake_active", fsm_state, 2);

        // Timeout on a silent PHY
        link_err = 1'b1;
        step();
        link_err = 1'b0;
        pl_state_sts = 4'h0;
        step();
        check("tmo_pre_reset", fsm_state, 0);
        link_up_req = 1'b1;
        step();
        link_up_req = 1'b0;
        for (int c = 0; c < TMO - 1; c++) step();
        check("tmo_not_yet", fsm_state, 1);
        step();
        check("tmo_error_state", fsm_state, 6);
        check("tmo_flag", tmo_err, 1);
        check("tmo_linkerror", lp_linkerror, 1);
        check("tmo_req_code", lp_state_req, 4'hA);
        step();
        check("tmo_back_reset", fsm_state, 0);
        check("tmo_sticky", tmo_err, 1);

        // Error with queued data, then reset mid-stream
        bring_up();
        pl_trdy = 1'b0;
        push_words(3, 32'h31);
        link_err = 1'b1;
        step();
        link_err = 1'b0;
        check("err_state", fsm_state, 6);
        check("err_flush", fifo_level, 0);
        pl_state_sts = 4'h0;
        step();
        bring_up();
        push_words(2, 32'h41);
        pl_trdy = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        check("rst_fsm", fsm_state, 0);
        check("rst_level", fifo_level, 0);
        check("rst_valid", lp_valid, 0);
        check("rst_tmo", tmo_err, 0);
        check("rst_clk_ack", lp_clk_ack, 0);
        rst_n = 1'b1;
        pl_trdy = 1'b0;

        // Randomized traffic with a loosely cooperating PHY
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      pl_state_sts = (exp_req() == 4'hA) ? 4'h0 : exp_req();
            else if (r < 72) pl_state_sts = 4'hA;
            else             pl_state_sts = 4'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) ? 1 : 4));
            rst_n       = ($urandom_range(0, 199) != 0);
            in_valid    = ($urandom_range(0, 9) < 6);
            in_data     = W'($urandom);
            link_up_req = ($urandom_range(0, 9) < 3);
            pm_req      = ($urandom_range(0, 9) < 1);
            link_err    = ($urandom_range(0, 99) == 0);
            pl_trdy     = ($urandom_range(0, 9) < 6);
            pl_stallreq = ($urandom_range(0, 9) < 2);
            pl_wake_ack = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rdi_tx_adapter.md
Name: rdi_tx_adapter

Overview:
Parametrised adapter-side (lp_) transmit controller for the UCIe-style Raw Die-to-Die Interface (RDI).
- Buffers mainband data from the upper layer in a FIFO_DEPTH x NBYTES*8 FIFO and drives the lp_valid/lp_irdy/pl_trdy data handshake.
- Owns the lp_state_req state machine (Reset/Active/L1/LinkError), the stall handshake, the wake handshake and the clock-request handshake, with a timeout on every PHY response.
- Sits between the memory-controller link layer and the PHY RDI port.

Parameters:
NBYTES, 64, mainband lanes/bytes per transfer; data width NBYTES*8
FIFO_DEPTH, 4, TX buffer entries; power of 2, >=2
TMO_CYCLES, 1024, max cycles waiting for a PHY state/wake response before error; >=2
CNT_W, $clog2(TMO_CYCLES+1), timeout counter width

Ports:
lclk  in  1  RDI clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upper-layer data valid
in_ready  out  1  FIFO can accept
in_data  in  NBYTES*8  upper-layer data
link_up_req  in  1  request link Active (also wakes from L1)
pm_req  in  1  request L1 entry
link_err  in  1  upper-layer fatal error, level
lp_irdy  out  1  adapter ready (equals lp_valid)
lp_valid  out  1  data valid to PHY
lp_data  out  NBYTES*8  FIFO head; 0 when lp_valid=0
pl_trdy  in  1  PHY accepts data
lp_state_req  out  4  state request to PHY
lp_linkerror  out  1  link error indication
pl_state_sts  in  4  PHY state status
pl_stallreq  in  1  PHY stall request
lp_stallack  out  1  stall acknowledge
pl_clk_req  in  1  PHY clock request
lp_clk_ack  out  1  clock acknowledge
lp_wake_req  out  1  wake request
pl_wake_ack  in  1  wake acknowledge
fsm_state  out  3  current FSM state encoding
tmo_err  out  1  sticky timeout flag; cleared only by reset
fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n=0 sampled at lclk): every output is 0, FIFO empty, FSM=RESET, counter=0.
- State encodings: NOP=4'h0, ACTIVE=4'h1, L1=4'h4, LINKERROR=4'hA. pl_state_sts uses the same codes, with RESET=4'h0.
- FSM states and transitions:
  - RESET(0): lp_state_req=NOP. On link_up_req -> ACT_REQ.
  - ACT_REQ(1): lp_state_req=ACTIVE. On pl_state_sts==ACTIVE -> ACTIVE.
  - ACTIVE(2): lp_state_req=ACTIVE. On pm_req && FIFO empty && lp_stallack==0 -> L1_REQ. A non-empty FIFO holds off L1 entry.
  - L1_REQ(3): lp_state_req=L1. On pl_state_sts==L1 -> L1.
  - L1(4): lp_state_req=NOP. On link_up_req -> WAKE.
  - WAKE(5): lp_wake_req=1. On pl_wake_ack -> ACT_REQ, with lp_wake_req deasserted in that same registered update.
  - ERROR(6): lp_linkerror=1, lp_state_req=LINKERROR. FIFO is flushed on entry. On link_err==0 && pl_state_sts==RESET -> RESET.
- Error entry: any state goes to ERROR on link_err=1 or pl_state_sts==LINKERROR; this has priority over every other transition.
- Timeout:
  - Counter clears on each state change and increments every cycle spent in ACT_REQ, L1_REQ or WAKE.
  - On reaching TMO_CYCLES: -> ERROR and tmo_err<=1.
- Data path:
  - in_ready = !full && FSM==ACTIVE && !pl_stallreq && !lp_stallack.
  - lp_valid = lp_irdy = !empty && FSM==ACTIVE && !lp_stallack && pl_state_sts==ACTIVE. Combinational from registered state.
  - Transfer occurs when lp_valid && pl_trdy; the head is popped. Zero-latency read: the next head is presented the following cycle.
  - Push and pop in the same cycle are legal when full; level is unchanged.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally. No overflow or underflow is possible by construction.
- Stall:
  - pl_stallreq sampled high -> lp_stallack=1 the next cycle. From that cycle lp_valid is forced 0.
  - Data not yet accepted stays in the FIFO; there is no loss or duplication.
  - lp_stallack stays 1 while pl_stallreq=1 and drops the cycle after pl_stallreq drops.
  - A stall during ERROR is still acknowledged.
- Clock handshake: lp_clk_ack = pl_clk_req registered, i.e. 1-cycle follow in both directions, in all FSM states.
- Simultaneous pm_req and link_up_req in ACTIVE: pm_req wins. In L1, link_up_req wins.
- Reset mid-transfer discards FIFO contents and returns to RESET within 1 cycle.

Decomposition:
- Package rdi_pkg:
  - typedef enum logic [3:0] rdi_state_e (NOP, ACTIVE, L1, LINKERROR).
  - typedef enum logic [2:0] tx_fsm_e (RESET..ERROR).
- Sub-module rdi_tx_fifo, parametrised by width and depth, with push/pop/flush/level.
- FSM, timeout counter and handshakes stay in rdi_tx_adapter.

Test Plan:
- Bring-up: link_up_req=1; PHY returns pl_state_sts=4'h1 3 cycles later -> lp_state_req=4'h1 from cycle 1, FSM=ACTIVE, in_ready=1.
- Streaming with backpressure: push 6 words 0x1..0x6 with FIFO_DEPTH=4, pl_trdy low 5 cycles then high -> in_ready drops at level 4, lp_data order 0x1..0x6, level returns to 0.
- Stall mid-stream: pl_stallreq for 4 cycles while lp_valid=1, pl_trdy=0 -> lp_stallack 1 cycle later, lp_valid=0 throughout, head word resent after release with no gap or duplicate.
- L1 round-trip: pm_req with FIFO non-empty -> stays ACTIVE until drained. Then lp_state_req=4'h4; sts=4'h4 -> L1. link_up_req -> lp_wake_req until pl_wake_ack -> ACT_REQ -> ACTIVE.
- Timeout: ACT_REQ with PHY silent for TMO_CYCLES=16 -> ERROR at cycle 16, tmo_err=1, lp_linkerror=1, lp_state_req=4'hA. sts=4'h0 -> RESET, tmo_err stays 1.
- Error/reset: link_err pulse with 3 words queued -> ERROR next cycle, level=0. rst_n low mid-stream -> all outputs 0 next cycle; lp_clk_ack tracks pl_clk_req with 1-cycle lag throughout.
